// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded-op records into 32-bit ISA words and queues them for the kernel loader (optional ENCODER_RANGE_CHECK_EN adds immediate range checks)
`ifndef OPCODE_R
`define OPCODE_R      3'b000
`define OPCODE_I      3'b001
`define OPCODE_F      3'b010
`define OPCODE_M      3'b011
`define OPCODE_UP     3'b100
`define OPCODE_J      3'b101
`define OPCODE_SX_SLT 3'b110
`endif
module instruction_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_DEPTH = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [3:0]                    in_funct,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [31:0]                   in_imm,
  input  logic                          in_scalar,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_word,
  output logic [$clog2(IMEM_DEPTH)-1:0] out_addr,
  input  logic                          addr_load,
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr_value,
  output logic                          err_flag,
  output logic [1:0]                    err_code,
  input  logic                          err_clear,
  output logic [15:0]                   word_count
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [31:0] word;
  logic [1:0] code;
  logic [2:0] f3;
  logic fit_i, fit_m, fit_b, fit_j, lui_ok;
  logic accept, push, bad, pop;
  assign f3 = in_funct[2:0];
`ifdef ENCODER_RANGE_CHECK_EN
  assign fit_i  = &in_imm[31:13] | ~|in_imm[31:13];
  assign fit_m  = &in_imm[31:14] | ~|in_imm[31:14];
  assign fit_b  = &in_imm[31:15] | ~|in_imm[31:15];
  assign fit_j  = &in_imm[31:25] | ~|in_imm[31:25];
  assign lui_ok = ~|in_imm[11:0];
`else
  assign fit_i  = 1'b1;
  assign fit_m  = 1'b1;
  assign fit_b  = 1'b1;
  assign fit_j  = 1'b1;
  assign lui_ok = 1'b1;
`endif
  // pack the record into its class layout and classify it (00 = emit)
  always_comb begin
    word = '0;
    code = 2'b01;
    case (in_opcode)
      `OPCODE_R: begin
        word = {in_opcode, in_scalar, 9'd0, in_rs2, in_funct, in_rs1, in_rd};
        code = in_funct <= 4'd9 ? 2'b00 : 2'b01;
      end
      `OPCODE_F: begin
        word = {in_opcode, in_scalar, 9'd0, in_rs2, in_funct, in_rs1, in_rd};
        code = in_funct <= 4'd10 ? 2'b00 : 2'b01;
      end
      `OPCODE_SX_SLT: begin
        word = {in_opcode, 1'b0, 9'd0, in_rs2, in_funct, in_rs1, in_rd};
        code = in_funct == 4'd0 ? 2'b00 : 2'b01;
      end
      `OPCODE_I: begin
        word = {in_opcode, in_scalar, in_imm[13:0], in_funct, in_rs1, in_rd};
        code = !(in_funct inside {4'd0, 4'd2, 4'd3, 4'd10}) ? 2'b01 : fit_i ? 2'b00 : 2'b10;
      end
      `OPCODE_M: begin
        word = f3[0] ? {in_opcode, in_imm[14:5], in_rs2, in_scalar, f3, in_rs1, in_imm[4:0]}
                     : {in_opcode, in_imm[14:0], in_scalar, f3, in_rs1, in_rd};
        code = f3[2] ? 2'b01 : fit_m ? 2'b00 : 2'b10;
      end
      `OPCODE_UP: begin
        word = {in_opcode, in_imm[31:12], 3'd0, in_scalar, in_rd};
        code = lui_ok ? 2'b00 : 2'b11;
      end
      `OPCODE_J: begin
        case (f3)
          3'b000: begin
            word = {in_opcode, in_imm[25:10], 3'b000, in_imm[9:0]};
            code = fit_j ? 2'b00 : 2'b10;
          end
          3'b001: begin
            word = {in_opcode, in_imm[15:6], in_rs2, in_imm[5], 3'b001, in_rs1, in_imm[4:0]};
            code = fit_b ? 2'b00 : 2'b10;
          end
          3'b110, 3'b111: begin
            word = {in_opcode, 16'd0, f3, 10'd0};
            code = 2'b00;
          end
          default: code = 2'b01;
        endcase
      end
      default: code = 2'b01;
    endcase
  end
  assign in_ready  = count != (PW+1)'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign out_word  = out_valid ? mem[rd_ptr] : '0;
  assign accept    = in_valid && in_ready;
  assign push      = accept && code == 2'b00;
  assign bad       = accept && code != 2'b00;
  assign pop       = out_valid && out_ready;
  // word storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= word;
  // FIFO pointers, loader address, word counter and sticky error state
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_addr   <= AW'(BASE_ADDR);
      err_flag   <= 1'b0;
      err_code   <= 2'b00;
      word_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (addr_load && !out_valid) out_addr <= addr_value;
      else if (pop) out_addr <= out_addr == AW'(IMEM_DEPTH-1) ? '0 : out_addr + 1'b1;
      if (pop) word_count <= word_count + 16'd1;
      if (bad) begin
        err_flag <= 1'b1;
        if (!err_flag) err_code <= code;
      end else if (err_clear) begin
        err_flag <= 1'b0;
        err_code <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: table-driven encoding checks with a scoreboard on the output port
module tb_instruction_encoder;
  localparam logic [2:0] OP_R = 3'd0, OP_I = 3'd1, OP_F = 3'd2, OP_M = 3'd3,
                         OP_UP = 3'd4, OP_J = 3'd5, OP_SX = 3'd6, OP_BAD = 3'd7;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [3:0]  f;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        sc;
    logic        legal;
    logic [31:0] word;
  } rec_t;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, in_scalar = 0, out_valid, out_ready = 0;
  logic [2:0] in_opcode = 0;
  logic [3:0] in_funct = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_word;
  logic [9:0] out_addr, addr_value = 0, exp_addr = 0;
  logic addr_load = 0, err_flag, err_clear = 0;
  logic [1:0] err_code;
  logic [15:0] word_count, exp_count = 0;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  rec_t tv[17];
  instruction_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_scalar(in_scalar), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr), .addr_load(addr_load),
    .addr_value(addr_value), .err_flag(err_flag), .err_code(err_code),
    .err_clear(err_clear), .word_count(word_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic rec_t mk(logic [2:0] op, logic [3:0] f, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm, logic sc, logic legal,
                              logic [31:0] w);
    rec_t r;
    r.op = op; r.f = f; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.imm = imm; r.sc = sc; r.legal = legal; r.word = w;
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // called and returns at posedge+1; records an accepted legal word in the scoreboard
  task automatic send(input rec_t r);
    int n = 0;
    in_opcode = r.op; in_funct = r.f; in_rd = r.rd; in_rs1 = r.rs1;
    in_rs2 = r.rs2; in_imm = r.imm; in_scalar = r.sc; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    if (r.legal) q.push_back(r.word);
    #1 in_valid = 0;
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(negedge clk);
    chk("word_count", word_count, exp_count);
    step;
  endtask
  task automatic err_expect(input logic f, input logic [1:0] c);
    @(negedge clk);
    chk("err_flag", err_flag, f);
    chk("err_code", err_code, c);
    step;
  endtask
  task automatic clear_err;
    err_clear = 1;
    step;
    err_clear = 0;
    err_expect(0, 2'b00);
  endtask
  // scoreboard side: every word the loader takes must be the next expected one at the next address
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_word, 32'hxxxxxxxx);
      else chk("out_word", out_word, q.pop_front());
      chk("out_addr", 32'(out_addr), 32'(exp_addr));
      exp_addr = exp_addr + 10'd1;
      exp_count = exp_count + 16'd1;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
  initial begin
    tv[0]  = mk(OP_M,  4'd1,  0,  2,  7, 32'h00000025, 1, 1, 32'h6009E445);
    tv[1]  = mk(OP_J,  4'd1,  0,  4,  0, 32'hFFFF8021, 0, 1, 32'hB0002481);
    tv[2]  = mk(OP_J,  4'd0,  0,  0,  0, 32'hFFFFFFFC, 0, 1, 32'hBFFFE3FC);
    tv[3]  = mk(OP_R,  4'd3,  5,  6,  7, 32'h0,        1, 1, 32'h1001CCC5);
    tv[4]  = mk(OP_SX, 4'd0,  1,  2,  3, 32'h0,        1, 1, 32'hC000C041);
    tv[5]  = mk(OP_UP, 4'd0,  9,  0,  0, 32'h12345000, 1, 1, 32'h82468A29);
    tv[6]  = mk(OP_M,  4'd0,  2,  1,  0, 32'hFFFFFFFE, 0, 1, 32'h7FFF8022);
    tv[7]  = mk(OP_F,  4'd10, 31, 31, 31, 32'h0,       0, 1, 32'h4007EBFF);
    tv[8]  = mk(OP_J,  4'd7,  5,  5,  5, 32'hFFFFFFFF, 1, 1, 32'hA0001C00);
    tv[9]  = mk(OP_I,  4'd10, 4,  8,  0, 32'h00001FFF, 1, 1, 32'h37FFE904);
    tv[10] = mk(OP_R,  4'd15, 1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[11] = mk(OP_I,  4'd1,  1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[12] = mk(OP_BAD, 4'd0, 1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[13] = mk(OP_J,  4'd2,  1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[14] = mk(OP_SX, 4'd1,  1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[15] = mk(OP_M,  4'd4,  1,  1,  1, 32'h0,        0, 0, 32'h0);
    tv[16] = mk(OP_F,  4'd11, 1,  1,  1, 32'h0,        0, 0, 32'h0);
    step; step;
    reset = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_err", {err_flag, err_code}, 0);
    chk("rst_word_count", word_count, 0);
    step;
    send(mk(OP_I, 4'd0, 3, 1, 0, 32'hFFFFFFFF, 0, 1, 32'h2FFFC023));
    @(negedge clk);
    chk("addi_latency_valid", out_valid, 1);
    chk("addi_word", out_word, 32'h2FFFC023);
    chk("addi_addr", 32'(out_addr), 0);
    step;
    out_ready = 1;
    drain;
    @(negedge clk);
    chk("addi_addr_after", 32'(out_addr), 1);
    step;
    reset = 1;
    step;
    reset = 0;
    exp_addr = 0; exp_count = 0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(tv[i]);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    step;
    fork
      send(tv[4]);
      begin
        repeat (3) @(negedge clk);
        chk("held_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain;
    for (int i = 5; i < 17; i++) begin
      send(tv[i]);
      if (!tv[i].legal) begin
        err_expect(1, 2'b01);
        clear_err;
      end
    end
    drain;
    send(tv[10]);
    err_expect(1, 2'b01);
    send(mk(OP_I, 4'd0, 1, 0, 0, 32'd9000, 0, !RC, 32'h28CA0001));
    err_expect(1, 2'b01);
    err_clear = 1;
    send(tv[11]);
    err_clear = 0;
    err_expect(1, 2'b01);
    clear_err;
    send(mk(OP_I, 4'd0, 1, 0, 0, 32'd9000, 0, !RC, 32'h28CA0001));
    err_expect(RC, RC ? 2'b10 : 2'b00);
    if (RC) clear_err;
    send(mk(OP_UP, 4'd0, 2, 0, 0, 32'h00001123, 0, !RC, 32'h80000202));
    err_expect(RC, RC ? 2'b11 : 2'b00);
    if (RC) clear_err;
    drain;
    addr_load = 1; addr_value = 10'd1023;
    step;
    addr_load = 0;
    exp_addr = 10'd1023;
    @(negedge clk);
    chk("addr_load", 32'(out_addr), 1023);
    step;
    send(tv[3]);
    send(tv[4]);
    drain;
    out_ready = 0;
    send(tv[5]);
    addr_load = 1; addr_value = 10'd5;
    step;
    addr_load = 0;
    @(negedge clk);
    chk("addr_load_ignored", 32'(out_addr), 32'(exp_addr));
    step;
    out_ready = 1;
    drain;
    out_ready = 0;
    send(tv[6]);
    send(tv[7]);
    reset = 1;
    step;
    reset = 0;
    q.delete();
    exp_addr = 0; exp_count = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_addr", 32'(out_addr), 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_word_count", word_count, 0);
    step;
    out_ready = 1;
    send(tv[8]);
    drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
